// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor, LSB first.
// One full_adder plus a carry flip-flop process one bit per cycle.
// Build option: define SERIAL_ADD_CTRL_SUB_EN to make op_sub functional.
// Without it, op_sub is ignored and every operation is an add.
//
// Handshake: start is sampled only while busy=0 (IDLE) and is ignored otherwise.
// An accepted start raises busy on the next cycle. busy stays high for WIDTH+1 cycles:
// WIDTH adder cycles followed by one DONE cycle. done pulses for exactly that DONE cycle.
// result and carry_out are valid from the done cycle until the next accepted start.

module full_adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic [1:0]       fsm_state
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic             accept, step;
   logic [WIDTH-1:0] a_sh, b_sh, result_q, result_n, sum_vec;
   logic             sub_q, carry_ff, sub_in;
   logic [CW-1:0]    cnt;
   logic             fa_sum, fa_cout, b_bit;

`ifdef SERIAL_ADD_CTRL_SUB_EN
   assign sub_in = op_sub;
`else
   // op_sub stays on the port for pin compatibility; adds only in this build.
   logic unused_op_sub;
   assign unused_op_sub = op_sub;
   assign sub_in        = 1'b0;
`endif

   // Subtraction is a + ~b + 1: b is inverted here and the carry starts at 1.
   assign b_bit = b_sh[0] ^ sub_q;

   full_adder u_fa (
      .x    (a_sh[0]),
      .y    (b_bit),
      .cin  (carry_ff),
      .s    (fa_sum),
      .cout (fa_cout)
   );

   // Sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
   assign sum_vec  = WIDTH'(fa_sum);
   assign result_n = (result_q >> 1) | (sum_vec << (WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state and control outputs.
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      step    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_n = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == CW'(WIDTH - 1)) state_n = S_DONE;
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Operand capture and one serial adder step per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         sub_q    <= 1'b0;
         carry_ff <= 1'b0;
         cnt      <= '0;
         result_q <= '0;
      end else if (accept) begin
         a_sh     <= a;
         b_sh     <= b;
         sub_q    <= sub_in;
         carry_ff <= sub_in;
         cnt      <= '0;
      end else if (step) begin
         a_sh     <= a_sh >> 1;
         b_sh     <= b_sh >> 1;
         carry_ff <= fa_cout;
         result_q <= result_n;
         cnt      <= cnt + CW'(1);
      end
   end

   assign result    = result_q;
   assign carry_out = carry_ff;
   assign fsm_state = state;
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op_sub  input  1  1 = subtract (a - b), 0 = add; sampled with start.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  single-cycle pulse; result valid.
REQ-010 result  output  WIDTH  sum/difference; held until next accepted start.
REQ-011 carry_out  output  1  final carry (subtract: 1 = no borrow); held with result.

Function
REQ-012 Block SHALL compute a +/- b bit-serially, LSB first, through exactly one full_adder instance plus one carry flip-flop.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE with start=1: capture a, b, op_sub into shift registers; carry FF <= op_sub; bit counter <= 0; next state RUN.
REQ-015 IDLE with start=0: remain IDLE; result/carry_out unchanged.
REQ-016 RUN: each cycle feed a[i], b[i] (b[i] inverted when subtracting) and carry FF into the adder; shift sum bit into result from MSB side; carry FF <= adder carry_out; counter increments.
REQ-017 RUN exits to DONE on the cycle the counter reaches WIDTH-1 (after exactly WIDTH adder cycles).
REQ-018 DONE: assert done for one cycle; result and carry_out final; next state IDLE unconditionally.
REQ-019 Latency: start accepted at edge N yields done high during cycle N+WIDTH+1; busy high for WIDTH+1 cycles.
REQ-020 start while busy=1 SHALL be ignored, without queuing and without disturbing the operation in progress.
REQ-021 Input changes on a, b, op_sub after capture SHALL not affect the operation in progress.
REQ-022 result SHALL show partial shifted values during RUN; only the value while done=1 or later is defined as valid.
REQ-023 WIDTH=1: exactly one RUN cycle, then DONE.
REQ-024 Counter width SHALL be $clog2(WIDTH+1); no wrap occurs before the RUN exit.

Reset
REQ-025 rst_n low SHALL, asynchronously, force state IDLE, busy=0, done=0, result=0, carry_out=0, counter=0, carry FF=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-027 Macro SERIAL_ADD_CTRL_SUB_EN defined: op_sub functional as in REQ-014/REQ-016.
REQ-028 SERIAL_ADD_CTRL_SUB_EN undefined: op_sub port present but ignored; all operations are add (carry FF <= 0, b not inverted).

Verification
REQ-029 WIDTH=8, start with a=0x0F, b=0x01, op_sub=0 -> done high 9 cycles after the start edge; result=0x10, carry_out=0.
REQ-030 a=0xFF, b=0x01, add -> result=0x00, carry_out=1; busy high for exactly 9 cycles.
REQ-031 SUB_EN defined, a=0x05, b=0x07, op_sub=1 -> result=0xFE, carry_out=0; a=0x07, b=0x05 -> result=0x02, carry_out=1.
REQ-032 start pulsed with a=0x33, b=0x11, then start re-asserted with a=0xAA during RUN -> single done, result=0x44.
REQ-033 rst_n pulsed low mid-RUN -> outputs 0 immediately with no done; next start with a=0x01, b=0x02 -> result=0x03.
REQ-034 SUB_EN undefined, a=0x05, b=0x07, op_sub=1 -> result=0x0C, carry_out=0.
